// File: rtl/gt_tx_framer.sv
// Transmit framer for the GT 16-bit/2-K user interface: it sends IDLE commas for alignment,
// periodic forced IDLEs and payload words. Optional test pattern mode: GT_TX_FRAMER_PATTERN_EN.
module gt_tx_framer #(
   parameter logic [15:0] g_IDLE        = 16'hBC95,
   parameter int unsigned g_IDLE_PERIOD = 32'd193,
   parameter int unsigned g_INIT_IDLES  = 32'd64
) (
   input  logic        usrclk_i,
   input  logic        rst_n_i,
   input  logic        en_i,
`ifdef GT_TX_FRAMER_PATTERN_EN
   input  logic        pattern_en_i,
`endif
   input  logic [15:0] data_i,
   input  logic        valid_i,
   output logic        ready_o,
   output logic [15:0] tx_data_o,
   output logic [1:0]  tx_k_o,
   output logic        link_up_o,
   output logic [31:0] words_sent_o
);

   localparam logic [1:0]  ST_DISABLED = 2'd0;
   localparam logic [1:0]  ST_INIT     = 2'd1;
   localparam logic [1:0]  ST_RUN      = 2'd2;
   localparam logic [1:0]  K_IDLE      = 2'b10;
   localparam logic [1:0]  K_DATA      = 2'b00;
   localparam logic [15:0] PERIOD_LAST = 16'(g_IDLE_PERIOD - 32'd1);
   localparam logic [15:0] INIT_LAST   = 16'(g_INIT_IDLES - 32'd1);
   localparam logic [31:0] WORDS_MAX   = 32'hFFFF_FFFF;

   logic [1:0]  state_r,      state_s;
   logic [15:0] init_cnt_r,   init_cnt_s;
   logic [15:0] period_cnt_r, period_cnt_s;
   logic [15:0] tx_data_r,    tx_data_s;
   logic [1:0]  tx_k_r,       tx_k_s;
   logic        link_up_r,    link_up_s;
   logic [31:0] words_sent_r, words_sent_s;
   logic        slot_s;
   logic        take_s;
   logic [15:0] word_s;

   // A payload slot exists on every enabled RUN cycle except the forced-IDLE one.
   assign slot_s = (state_r == ST_RUN) && en_i && (period_cnt_r != 16'd0);

`ifdef GT_TX_FRAMER_PATTERN_EN
   logic [15:0] pat_cnt_r, pat_cnt_s;

   assign ready_o   = slot_s && !pattern_en_i;
   assign pat_cnt_s = ((state_r == ST_RUN) && en_i) ? (pat_cnt_r + 16'd1) : 16'd0;

   // Select between the pattern counter and the user payload for the slot.
   always_comb begin
      take_s = 1'b0;
      word_s = data_i;
      if (pattern_en_i) begin
         take_s = slot_s;
         word_s = pat_cnt_r;
      end else begin
         take_s = slot_s && valid_i;
         word_s = data_i;
      end
   end

   // Pattern counter: zero outside RUN so it restarts at every RUN entry.
   always_ff @(posedge usrclk_i) begin
      if (!rst_n_i) begin
         pat_cnt_r <= 16'd0;
      end else begin
         pat_cnt_r <= pat_cnt_s;
      end
   end
`else
   assign ready_o = slot_s;
   assign take_s  = slot_s && valid_i;
   assign word_s  = data_i;
`endif

   // Next-state, counter and next-output decode.
   always_comb begin
      state_s      = state_r;
      init_cnt_s   = init_cnt_r;
      period_cnt_s = period_cnt_r;
      link_up_s    = 1'b0;
      if (!en_i) begin
         state_s      = ST_DISABLED;
         init_cnt_s   = 16'd0;
         period_cnt_s = 16'd0;
      end else begin
         case (state_r)
            ST_DISABLED: begin
               state_s      = ST_INIT;
               init_cnt_s   = 16'd0;
               period_cnt_s = 16'd0;
            end
            ST_INIT: begin
               if (init_cnt_r == INIT_LAST) begin
                  state_s      = ST_RUN;
                  init_cnt_s   = 16'd0;
                  period_cnt_s = 16'd0;
               end else begin
                  init_cnt_s   = init_cnt_r + 16'd1;
               end
            end
            ST_RUN: begin
               link_up_s = 1'b1;
               if (period_cnt_r == PERIOD_LAST) begin
                  period_cnt_s = 16'd0;
               end else begin
                  period_cnt_s = period_cnt_r + 16'd1;
               end
            end
            default: begin
               state_s      = ST_DISABLED;
               init_cnt_s   = 16'd0;
               period_cnt_s = 16'd0;
            end
         endcase
      end

      // Payload equal to g_IDLE stays legal: only the K flags mark a comma.
      if (take_s) begin
         tx_data_s = word_s;
         tx_k_s    = K_DATA;
         if (words_sent_r != WORDS_MAX) begin
            words_sent_s = words_sent_r + 32'd1;
         end else begin
            words_sent_s = words_sent_r;
         end
      end else begin
         tx_data_s    = g_IDLE;
         tx_k_s       = K_IDLE;
         words_sent_s = words_sent_r;
      end
   end

   // State and output registers; reset wins over everything, en_i never clears the word count.
   always_ff @(posedge usrclk_i) begin
      if (!rst_n_i) begin
         state_r      <= ST_DISABLED;
         init_cnt_r   <= 16'd0;
         period_cnt_r <= 16'd0;
         tx_data_r    <= g_IDLE;
         tx_k_r       <= K_IDLE;
         link_up_r    <= 1'b0;
         words_sent_r <= 32'd0;
      end else begin
         state_r      <= state_s;
         init_cnt_r   <= init_cnt_s;
         period_cnt_r <= period_cnt_s;
         tx_data_r    <= tx_data_s;
         tx_k_r       <= tx_k_s;
         link_up_r    <= link_up_s;
         words_sent_r <= words_sent_s;
      end
   end

   assign tx_data_o    = tx_data_r;
   assign tx_k_o       = tx_k_r;
   assign link_up_o    = link_up_r;
   assign words_sent_o = words_sent_r;

endmodule

// File: tb/tb_gt_tx_framer.sv
// Self-checking bench for gt_tx_framer: randomized traffic against a cycle-index reference model.
module tb_gt_tx_framer;

   localparam logic [15:0] IDLE   = 16'hBC95;
   localparam int          PERIOD = 193;
   localparam int          INIT   = 64;

   logic        usrclk_i = 1'b0;
   logic        rst_n_i;
   logic        en_i;
   logic [15:0] data_i;
   logic        valid_i;
   logic        ready_o;
   logic [15:0] tx_data_o;
   logic [1:0]  tx_k_o;
   logic        link_up_o;
   logic [31:0] words_sent_o;
   logic        pat_mode = 1'b0;
`ifdef GT_TX_FRAMER_PATTERN_EN
   logic        pattern_en_i;
   assign pattern_en_i = pat_mode;
`endif

   gt_tx_framer dut (
      .usrclk_i     (usrclk_i),
      .rst_n_i      (rst_n_i),
      .en_i         (en_i),
`ifdef GT_TX_FRAMER_PATTERN_EN
      .pattern_en_i (pattern_en_i),
`endif
      .data_i       (data_i),
      .valid_i      (valid_i),
      .ready_o      (ready_o),
      .tx_data_o    (tx_data_o),
      .tx_k_o       (tx_k_o),
      .link_up_o    (link_up_o),
      .words_sent_o (words_sent_o)
   );

   always #5 usrclk_i = ~usrclk_i;

   int          n_cmp = 0;
   int          n_err = 0;
   // Model: t_en counts consecutive enabled cycles; RUN cycle n = t_en - 1 - INIT.
   int          t_en = 0;
   logic [31:0] exp_words = 32'd0;
   logic [15:0] exp_data;
   logic [1:0]  exp_k;
   logic        exp_link;
   logic        exp_ready;
   logic        obs_ready;

   task automatic step(input logic en, input logic vld, input logic [15:0] dat);
      int   n;
      logic in_run;
      logic slot;
      en_i = en; valid_i = vld; data_i = dat;
      #1;
      obs_ready = ready_o;
      in_run    = en && (t_en >= 1 + INIT);
      n         = t_en - 1 - INIT;
      slot      = in_run && ((n % PERIOD) != 0);
      exp_ready = slot && !pat_mode;
      exp_link  = in_run;
      exp_data  = IDLE;
      exp_k     = 2'b10;
      if (slot && pat_mode) begin
         exp_data = n[15:0];
         exp_k    = 2'b00;
         if (exp_words != 32'hFFFF_FFFF) exp_words = exp_words + 32'd1;
      end else if (exp_ready && vld) begin
         exp_data = dat;
         exp_k    = 2'b00;
         if (exp_words != 32'hFFFF_FFFF) exp_words = exp_words + 32'd1;
      end
      t_en = en ? t_en + 1 : 0;
      @(posedge usrclk_i);
      #1;
   endtask

   task automatic do_reset(input logic en);
      rst_n_i = 1'b0; en_i = en; valid_i = 1'b1; data_i = 16'($urandom);
      @(posedge usrclk_i);
      #1;
      rst_n_i   = 1'b1;
      t_en      = 0;
      exp_words = 32'd0;
   endtask

   task automatic test_reset;
      do_reset(1'b1);
      n_cmp++; if (tx_data_o !== IDLE) begin n_err++; $display("FAIL reset_data: got %h expected %h", tx_data_o, IDLE); end
      n_cmp++; if (tx_k_o !== 2'b10) begin n_err++; $display("FAIL reset_k: got %b expected 10", tx_k_o); end
      n_cmp++; if (link_up_o !== 1'b0) begin n_err++; $display("FAIL reset_link: got %b expected 0", link_up_o); end
      n_cmp++; if (words_sent_o !== 32'd0) begin n_err++; $display("FAIL reset_words: got %0d expected 0", words_sent_o); end
      n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b expected 0", ready_o); end
   endtask

   task automatic test_init;
      int up_at = -1;
      do_reset(1'b0);
      for (int i = 0; i < 200; i++) begin
         step(1'b1, 1'b0, 16'($urandom));
         n_cmp++; if (obs_ready !== exp_ready) begin n_err++; $display("FAIL init_ready: cyc %0d got %b expected %b", i, obs_ready, exp_ready); end
         n_cmp++; if ({tx_k_o, tx_data_o} !== {2'b10, IDLE}) begin n_err++; $display("FAIL init_idle: cyc %0d got %b/%h expected 10/%h", i, tx_k_o, tx_data_o, IDLE); end
         n_cmp++; if (link_up_o !== exp_link) begin n_err++; $display("FAIL init_link: cyc %0d got %b expected %b", i, link_up_o, exp_link); end
         if (link_up_o === 1'b1) begin
            up_at = i + 1;
            break;
         end
      end
      n_cmp++; if (up_at != 1 + INIT + 1) begin n_err++; $display("FAIL init_linkup_edge: got %0d expected %0d", up_at, 1 + INIT + 1); end
   endtask

   task automatic test_stream;
      logic [15:0] seq = 16'd0;
      int          idles = 0;
      do_reset(1'b1);
      for (int i = 0; i < 1 + INIT; i++) step(1'b1, 1'b0, 16'd0);
      for (int i = 0; i < 1000; i++) begin
         step(1'b1, 1'b1, seq);
         if (obs_ready === 1'b1) seq = seq + 16'd1;
         if (tx_k_o === 2'b10) idles++;
         n_cmp++; if (obs_ready !== exp_ready) begin n_err++; $display("FAIL stream_ready: run %0d got %b expected %b", i, obs_ready, exp_ready); end
         n_cmp++; if ({tx_k_o, tx_data_o} !== {exp_k, exp_data}) begin n_err++; $display("FAIL stream_word: run %0d got %b/%h expected %b/%h", i, tx_k_o, tx_data_o, exp_k, exp_data); end
      end
      n_cmp++; if (idles != (1000 + PERIOD - 1) / PERIOD) begin n_err++; $display("FAIL stream_idles: got %0d expected %0d", idles, (1000 + PERIOD - 1) / PERIOD); end
      n_cmp++; if (words_sent_o !== 32'(1000 - (1000 + PERIOD - 1) / PERIOD)) begin n_err++; $display("FAIL stream_words: got %0d expected %0d", words_sent_o, 1000 - (1000 + PERIOD - 1) / PERIOD); end
   endtask

   task automatic test_random_valid;
      logic [15:0] d = 16'($urandom);
      logic        v;
      for (int i = 0; i < 600; i++) begin
         v = 1'($urandom);
         if (i % 50 == 7) d = IDLE;
         step(1'b1, v, d);
         if (v && obs_ready === 1'b1) d = 16'($urandom);
         n_cmp++; if (obs_ready !== exp_ready) begin n_err++; $display("FAIL rand_ready: cyc %0d got %b expected %b", i, obs_ready, exp_ready); end
         n_cmp++; if ({tx_k_o, tx_data_o} !== {exp_k, exp_data}) begin n_err++; $display("FAIL rand_word: cyc %0d got %b/%h expected %b/%h", i, tx_k_o, tx_data_o, exp_k, exp_data); end
         n_cmp++; if (words_sent_o !== exp_words) begin n_err++; $display("FAIL rand_words: cyc %0d got %0d expected %0d", i, words_sent_o, exp_words); end
      end
   endtask

   task automatic test_en_drop;
      logic [31:0] saved;
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 16'($urandom));
      saved = exp_words;
      step(1'b0, 1'b1, 16'h1234);
      n_cmp++; if (obs_ready !== 1'b0) begin n_err++; $display("FAIL drop_ready: got %b expected 0", obs_ready); end
      n_cmp++; if ({tx_k_o, tx_data_o} !== {2'b10, IDLE}) begin n_err++; $display("FAIL drop_idle: got %b/%h expected 10/%h", tx_k_o, tx_data_o, IDLE); end
      n_cmp++; if (link_up_o !== 1'b0) begin n_err++; $display("FAIL drop_link: got %b expected 0", link_up_o); end
      n_cmp++; if (words_sent_o !== saved) begin n_err++; $display("FAIL drop_words: got %0d expected %0d", words_sent_o, saved); end
      for (int i = 0; i < 1 + INIT + 3; i++) begin
         step(1'b1, 1'b1, 16'h1234);
         n_cmp++; if (obs_ready !== exp_ready) begin n_err++; $display("FAIL reinit_ready: cyc %0d got %b expected %b", i, obs_ready, exp_ready); end
         n_cmp++; if ({link_up_o, tx_k_o, tx_data_o} !== {exp_link, exp_k, exp_data}) begin n_err++; $display("FAIL reinit_out: cyc %0d got %b %b/%h expected %b %b/%h", i, link_up_o, tx_k_o, tx_data_o, exp_link, exp_k, exp_data); end
         n_cmp++; if (words_sent_o !== exp_words) begin n_err++; $display("FAIL reinit_words: cyc %0d got %0d expected %0d", i, words_sent_o, exp_words); end
      end
   endtask

   task automatic test_reset_mid_run;
      for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 16'($urandom));
      do_reset(1'b1);
      n_cmp++; if ({tx_k_o, tx_data_o} !== {2'b10, IDLE}) begin n_err++; $display("FAIL midrst_idle: got %b/%h expected 10/%h", tx_k_o, tx_data_o, IDLE); end
      n_cmp++; if (link_up_o !== 1'b0) begin n_err++; $display("FAIL midrst_link: got %b expected 0", link_up_o); end
      n_cmp++; if (words_sent_o !== 32'd0) begin n_err++; $display("FAIL midrst_words: got %0d expected 0", words_sent_o); end
      for (int i = 0; i < 1 + INIT + 2; i++) begin
         step(1'b1, 1'b1, 16'($urandom));
         n_cmp++; if ({link_up_o, tx_k_o, tx_data_o} !== {exp_link, exp_k, exp_data}) begin n_err++; $display("FAIL midrst_relink: cyc %0d got %b %b/%h expected %b %b/%h", i, link_up_o, tx_k_o, tx_data_o, exp_link, exp_k, exp_data); end
      end
   endtask

`ifdef GT_TX_FRAMER_PATTERN_EN
   task automatic test_pattern;
      do_reset(1'b1);
      pat_mode = 1'b1;
      for (int i = 0; i < 1 + INIT; i++) step(1'b1, 1'b1, 16'($urandom));
      for (int i = 0; i < 65536 + 300; i++) begin
         step(1'b1, 1'b1, 16'($urandom));
         n_cmp++; if (obs_ready !== 1'b0) begin n_err++; $display("FAIL pat_ready: run %0d got %b expected 0", i, obs_ready); end
         n_cmp++; if ({tx_k_o, tx_data_o} !== {exp_k, exp_data}) begin n_err++; $display("FAIL pat_word: run %0d got %b/%h expected %b/%h", i, tx_k_o, tx_data_o, exp_k, exp_data); end
      end
      n_cmp++; if (words_sent_o !== exp_words) begin n_err++; $display("FAIL pat_words: got %0d expected %0d", words_sent_o, exp_words); end
      pat_mode = 1'b0;
   endtask
`endif

   initial begin
      rst_n_i = 1'b0; en_i = 1'b0; valid_i = 1'b0; data_i = 16'd0;
      test_reset();
      test_init();
      test_stream();
      test_random_valid();
      test_en_drop();
      test_reset_mid_run();
`ifdef GT_TX_FRAMER_PATTERN_EN
      test_pattern();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
